// File: rtl/synth_pkg.sv
// Shared types and constants for the per-voice wavetable DAC path.
package synth_pkg;
  localparam int WAVE_COUNT       = 64;
  localparam int SAMPLES_PER_WAVE = 128;
  localparam int WAVE_ADDR_W      = $clog2(WAVE_COUNT) + $clog2(SAMPLES_PER_WAVE);

  localparam int         FRAME_W         = 16;
  localparam int         DAC_DATA_W      = 12;
  localparam logic [3:0] DAC_CFG_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH
  } state_t;
endpackage

// File: rtl/wave_dac_driver_if.sv
// Wavetable RAM read port: the driver is master, the RAM is slave.
interface wave_dac_driver_if
  import synth_pkg::*;
#(
  parameter int ADDR_W   = WAVE_ADDR_W,
  parameter int SAMPLE_W = 8
) ();
  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_rd_en;
  logic [SAMPLE_W-1:0] ram_data;

  modport master (output ram_addr, output ram_rd_en, input ram_data);
  modport slave  (input ram_addr, input ram_rd_en, output ram_data);
endinterface

// File: rtl/spi_tx_shifter.sv
// 16-bit MSB-first SPI transmitter: CLK_DIV cycles low then CLK_DIV high per bit.
module spi_tx_shifter
  import synth_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [FRAME_W-1:0] i_frame,
  output logic               o_cs_n,
  output logic               o_sclk,
  output logic               o_mosi,
  output logic               o_done
);
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  logic [FRAME_W-1:0] r_shift;
  logic [4:0]         r_bits_left;
  logic [DIV_W-1:0]   r_div;
  logic               r_cs_n;
  logic               r_sclk;
  logic               r_mosi;
  logic               w_phase_end;
  logic               w_last;

  assign w_phase_end = !r_cs_n && (r_div == '0);
  // Combinational so the controller can leave SHIFT on the same edge cs_n rises.
  assign w_last      = w_phase_end && r_sclk && (r_bits_left == '0);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shift     <= '0;
      r_bits_left <= '0;
      r_div       <= '0;
      r_cs_n      <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
    end else if (i_start) begin
      r_shift     <= {i_frame[FRAME_W-2:0], 1'b0};
      r_bits_left <= 5'(FRAME_W - 1);
      r_div       <= DIV_LOAD;
      r_cs_n      <= 1'b0;
      r_sclk      <= 1'b0;
      r_mosi      <= i_frame[FRAME_W-1];
    end else if (!r_cs_n) begin
      if (r_div != '0) begin
        r_div <= r_div - DIV_W'(1);
      end else begin
        r_div <= DIV_LOAD;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
        end else if (r_bits_left == '0) begin
          r_sclk <= 1'b0;
          r_cs_n <= 1'b1;
          r_mosi <= 1'b0;
        end else begin
          r_sclk      <= 1'b0;
          r_mosi      <= r_shift[FRAME_W-1];
          r_shift     <= {r_shift[FRAME_W-2:0], 1'b0};
          r_bits_left <= r_bits_left - 5'd1;
        end
      end
    end
  end

  assign o_cs_n = r_cs_n;
  assign o_sclk = r_sclk;
  assign o_mosi = r_mosi;
  assign o_done = w_last;
endmodule

// File: rtl/wave_dac_driver.sv
// Fetches the wavetable sample on every NCO address change and sends it to an
// MCP4921-style DAC. SIGNED_SAMPLE_EN: treat RAM samples as two's complement.
//
// state | meaning
// IDLE  | waiting for a pending address
// READ  | issue RAM read of the shadow address, clear pending
// WAIT  | RAM_LAT cycles of read latency, capture data at the end
// LOAD  | build frame, drop cs_n, present first bit
// SHIFT | serialise 16 bits
// LATCH | ldac_n low for CLK_DIV cycles, frame_done on release
module wave_dac_driver
  import synth_pkg::*;
#(
  parameter int         ADDR_W   = WAVE_ADDR_W,
  parameter int         SAMPLE_W = 8,
  parameter int         RAM_LAT  = 1,
  parameter int         CLK_DIV  = 2,
  parameter logic [3:0] DAC_CFG  = DAC_CFG_DEFAULT
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [ADDR_W-1:0]   i_address,
  wave_dac_driver_if.master   ram_bus,
  output logic                o_dac_cs_n,
  output logic                o_dac_sclk,
  output logic                o_dac_mosi,
  output logic                o_dac_ldac_n,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_busy,
  output logic                o_frame_done
);
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_W-1:0]       r_shadow;
  logic                    r_pending;
  logic [ADDR_W-1:0]       r_ram_addr;
  logic                    r_rd_en;
  logic [1:0]              r_wait_cnt;
  logic [SAMPLE_W-1:0]     r_capture;
  logic [SAMPLE_W-1:0]     r_sample;
  logic                    r_ldac_n;
  logic [DIV_W-1:0]        r_ldac_cnt;
  logic                    r_frame_done;
  logic                    w_read;
  logic                    w_capture;
  logic                    w_start;
  logic                    w_latch;
  logic                    w_release;
  logic                    w_shift_done;
  logic [SAMPLE_W-1:0]     w_conv;
  logic [DAC_DATA_W-1:0]   w_data12;
  logic [FRAME_W-1:0]      w_frame;

`ifdef SIGNED_SAMPLE_EN
  assign w_conv = r_capture ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
`else
  assign w_conv = r_capture;
`endif
  // Sample is left-justified in the 12-bit DAC word.
  assign w_data12 = DAC_DATA_W'(w_conv) << (DAC_DATA_W - SAMPLE_W);
  assign w_frame  = {DAC_CFG, w_data12};

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_read       = 1'b0;
    w_capture    = 1'b0;
    w_start      = 1'b0;
    w_latch      = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE:  if (r_pending) w_next_state = ST_READ;
      ST_READ: begin
        w_read       = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: if (r_wait_cnt == '0) begin
        w_capture    = 1'b1;
        w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_start      = 1'b1;
        w_next_state = ST_SHIFT;
      end
      ST_SHIFT: if (w_shift_done) begin
        w_latch      = 1'b1;
        w_next_state = ST_LATCH;
      end
      ST_LATCH: if (r_ldac_cnt == '0) begin
        w_release    = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shadow     <= '0;
      r_pending    <= 1'b1;
      r_ram_addr   <= '0;
      r_rd_en      <= 1'b0;
      r_wait_cnt   <= '0;
      r_capture    <= '0;
      r_sample     <= '0;
      r_ldac_n     <= 1'b1;
      r_ldac_cnt   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_rd_en      <= w_read;
      r_frame_done <= w_release;
      // A fresh change outranks the READ clear so it is never lost.
      if (i_address != r_shadow) begin
        r_shadow  <= i_address;
        r_pending <= 1'b1;
      end else if (w_read) begin
        r_pending <= 1'b0;
      end
      if (w_read) begin
        r_ram_addr <= r_shadow;
        r_wait_cnt <= 2'(RAM_LAT - 1);
      end else if (r_state == ST_WAIT && r_wait_cnt != '0) begin
        r_wait_cnt <= r_wait_cnt - 2'd1;
      end
      if (w_capture) r_capture <= ram_bus.ram_data;
      if (w_start)   r_sample  <= w_conv;
      if (w_latch) begin
        r_ldac_n   <= 1'b0;
        r_ldac_cnt <= DIV_LOAD;
      end else if (r_state == ST_LATCH) begin
        if (r_ldac_cnt != '0) r_ldac_cnt <= r_ldac_cnt - DIV_W'(1);
        else                  r_ldac_n   <= 1'b1;
      end
    end
  end

  spi_tx_shifter #(.CLK_DIV(CLK_DIV)) u_spi_tx (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (w_start),
    .i_frame (w_frame),
    .o_cs_n  (o_dac_cs_n),
    .o_sclk  (o_dac_sclk),
    .o_mosi  (o_dac_mosi),
    .o_done  (w_shift_done)
  );

  assign ram_bus.ram_addr  = r_ram_addr;
  assign ram_bus.ram_rd_en = r_rd_en;
  assign o_dac_ldac_n      = r_ldac_n;
  assign o_sample          = r_sample;
  assign o_busy            = (r_state != ST_IDLE);
  assign o_frame_done      = r_frame_done;
endmodule

// File: tb/tb_wave_dac_driver.sv
// Directed bench: instance A uses defaults (RAM_LAT=1, CLK_DIV=2), instance B uses RAM_LAT=3, CLK_DIV=1.
module tb_wave_dac_driver;
`ifdef SIGNED_SAMPLE_EN
  localparam logic [15:0] EXP_FR_A5 = 16'h3250;
  localparam logic [15:0] EXP_FR_80 = 16'h3000;
  localparam logic [15:0] EXP_FR_7F = 16'h3FF0;
  localparam logic [7:0]  EXP_SM_A5 = 8'h25;
  localparam logic [7:0]  EXP_SM_80 = 8'h00;
`else
  localparam logic [15:0] EXP_FR_A5 = 16'h3A50;
  localparam logic [15:0] EXP_FR_80 = 16'h3800;
  localparam logic [15:0] EXP_FR_7F = 16'h37F0;
  localparam logic [7:0]  EXP_SM_A5 = 8'hA5;
  localparam logic [7:0]  EXP_SM_80 = 8'h80;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [12:0] addr_a, addr_b;
  logic        cs_a, sclk_a, mosi_a, ldac_a, busy_a, done_a;
  logic        cs_b, sclk_b, mosi_b, ldac_b, busy_b, done_b;
  logic [7:0]  smp_a, smp_b;

  wave_dac_driver_if #(.ADDR_W(13), .SAMPLE_W(8)) ifa ();
  wave_dac_driver_if #(.ADDR_W(13), .SAMPLE_W(8)) ifb ();

  wave_dac_driver u_dut_a (
    .i_clock(clk), .i_reset(rst_a), .i_address(addr_a), .ram_bus(ifa),
    .o_dac_cs_n(cs_a), .o_dac_sclk(sclk_a), .o_dac_mosi(mosi_a), .o_dac_ldac_n(ldac_a),
    .o_sample(smp_a), .o_busy(busy_a), .o_frame_done(done_a)
  );

  wave_dac_driver #(.RAM_LAT(3), .CLK_DIV(1)) u_dut_b (
    .i_clock(clk), .i_reset(rst_b), .i_address(addr_b), .ram_bus(ifb),
    .o_dac_cs_n(cs_b), .o_dac_sclk(sclk_b), .o_dac_mosi(mosi_b), .o_dac_ldac_n(ldac_b),
    .o_sample(smp_b), .o_busy(busy_b), .o_frame_done(done_b)
  );

  function automatic logic [7:0] mem_f(input logic [12:0] a);
    case (a)
      13'd0:   return 8'hA5;
      13'd5:   return 8'h11;
      13'd6:   return 8'h22;
      13'd7:   return 8'h80;
      13'd8:   return 8'h7F;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // RAM models: data is valid only in the cycle the driver is due to capture it.
  assign ifa.ram_data = ifa.ram_rd_en ? mem_f(ifa.ram_addr) : 8'h00;
  logic [7:0] pb1 = 8'h00, pb2 = 8'h00;
  always @(posedge clk) begin
    pb1 <= ifb.ram_rd_en ? mem_f(ifb.ram_addr) : 8'h00;
    pb2 <= pb1;
  end
  assign ifb.ram_data = pb2;

  // Monitor A
  logic        p_cs_a = 1'b1, p_sclk_a = 1'b0, p_mosi_a = 1'b0, p_ldac_a = 1'b1;
  logic [15:0] bits_a = '0, frame_a = '0;
  logic [12:0] rd_addr_a = '0;
  int bitn_a = 0, cs_run_a = 0, cs_len_a = 0, ldac_run_a = 0, ldac_len_a = 0;
  int done_cnt_a = 0, rd_cnt_a = 0, busy_cnt_a = 0, edge_err_a = 0;
  always @(negedge clk) begin
    if (!cs_a) begin
      if (p_cs_a) begin bitn_a = 0; cs_run_a = 0; end
      cs_run_a++;
      if (sclk_a && !p_sclk_a) begin bits_a = {bits_a[14:0], mosi_a}; bitn_a++; end
      if (!p_cs_a && mosi_a !== p_mosi_a && !(p_sclk_a && !sclk_a)) edge_err_a++;
    end else if (!p_cs_a) begin
      frame_a = bits_a; cs_len_a = cs_run_a;
    end
    if (!ldac_a) ldac_run_a++;
    else if (!p_ldac_a) begin ldac_len_a = ldac_run_a; ldac_run_a = 0; end
    if (done_a) done_cnt_a++;
    if (ifa.ram_rd_en) begin rd_cnt_a++; rd_addr_a = ifa.ram_addr; end
    if (busy_a) busy_cnt_a++;
    p_cs_a = cs_a; p_sclk_a = sclk_a; p_mosi_a = mosi_a; p_ldac_a = ldac_a;
  end

  // Monitor B
  logic        p_cs_b = 1'b1, p_sclk_b = 1'b0, lat_on_b = 1'b0;
  logic [15:0] bits_b = '0, frame_b = '0;
  int cs_run_b = 0, cs_len_b = 0, done_cnt_b = 0, lat_run_b = 0, lat_b = 0;
  int cyc_b = 0, last_rise_b = 0, gap_b = 0;
  always @(negedge clk) begin
    cyc_b++;
    if (ifb.ram_rd_en) begin lat_run_b = 0; lat_on_b = 1'b1; end
    else if (lat_on_b) lat_run_b++;
    if (!cs_b) begin
      if (p_cs_b) begin
        cs_run_b = 0;
        if (lat_on_b) begin lat_b = lat_run_b; lat_on_b = 1'b0; end
      end
      cs_run_b++;
      if (sclk_b && !p_sclk_b) begin
        bits_b = {bits_b[14:0], mosi_b};
        gap_b = cyc_b - last_rise_b; last_rise_b = cyc_b;
      end
    end else if (!p_cs_b) begin
      frame_b = bits_b; cs_len_b = cs_run_b;
    end
    if (done_b) done_cnt_b++;
    p_cs_b = cs_b; p_sclk_b = sclk_b;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done_a(input int target, input int limit);
    int n = 0;
    while (done_cnt_a < target && n < limit) begin tick(1); n++; end
    chk("wait_done_a", 32'(done_cnt_a >= target), 32'd1);
  endtask

  task automatic wait_done_b(input int target, input int limit);
    int n = 0;
    while (done_cnt_b < target && n < limit) begin tick(1); n++; end
    chk("wait_done_b", 32'(done_cnt_b >= target), 32'd1);
  endtask

  task automatic wait_cs_low_a(input int limit);
    int n = 0;
    while (cs_a && n < limit) begin tick(1); n++; end
    chk("wait_cs_low_a", 32'(cs_a), 32'd0);
  endtask

  int base_done, base_rd, base_busy, n;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; addr_a = '0; addr_b = '0;
    tick(3);
    chk("rst_cs_n",   32'(cs_a),   32'd1);
    chk("rst_sclk",   32'(sclk_a), 32'd0);
    chk("rst_mosi",   32'(mosi_a), 32'd0);
    chk("rst_ldac_n", 32'(ldac_a), 32'd1);
    chk("rst_rd_en",  32'(ifa.ram_rd_en), 32'd0);
    chk("rst_ram_addr", 32'(ifa.ram_addr), 32'd0);
    chk("rst_sample", 32'(smp_a),  32'd0);
    chk("rst_busy",   32'(busy_a), 32'd0);
    chk("rst_done",   32'(done_a), 32'd0);
    chk("rst_cs_n_b", 32'(cs_b),   32'd1);

    // First frame after reset: sample at address 0
    rst_a = 1'b0; rst_b = 1'b0;
    wait_done_a(1, 300);
    wait_done_b(1, 300);
    tick(20);
    chk("a_frame0",   32'(frame_a),    32'(EXP_FR_A5));
    chk("a_cs_len",   32'(cs_len_a),   32'd64);
    chk("a_ldac_len", 32'(ldac_len_a), 32'd2);
    chk("a_done_once", 32'(done_cnt_a), 32'd1);
    chk("a_rd_once",  32'(rd_cnt_a),   32'd1);
    chk("a_sample0",  32'(smp_a),      32'(EXP_SM_A5));
    chk("b_frame0",   32'(frame_b),    32'(EXP_FR_A5));
    chk("b_cs_len",   32'(cs_len_b),   32'd32);
    chk("b_rd_to_cs", 32'(lat_b),      32'd4);
    chk("b_sclk_period", 32'(gap_b),   32'd2);
    chk("b_done_once", 32'(done_cnt_b), 32'd1);

    // Static address: nothing more happens
    base_rd = rd_cnt_a; base_busy = busy_cnt_a;
    tick(200);
    chk("static_rd",   32'(rd_cnt_a - base_rd),     32'd0);
    chk("static_busy", 32'(busy_cnt_a - base_busy), 32'd0);

    // Changes during one SHIFT coalesce to the newest address
    base_done = done_cnt_a; base_rd = rd_cnt_a;
    addr_a = 13'd5;
    wait_cs_low_a(50);
    tick(10); addr_a = 13'd6;
    tick(10); addr_a = 13'd7;
    wait_done_a(base_done + 2, 600);
    tick(100);
    chk("coal_done",   32'(done_cnt_a - base_done), 32'd2);
    chk("coal_rd",     32'(rd_cnt_a - base_rd),     32'd2);
    chk("coal_addr",   32'(rd_addr_a),              32'd7);
    chk("coal_frame",  32'(frame_a),                32'(EXP_FR_80));
    chk("coal_sample", 32'(smp_a),                  32'(EXP_SM_80));

    addr_a = 13'd8;
    wait_done_a(base_done + 3, 300);
    tick(5);
    chk("frame_7f", 32'(frame_a), 32'(EXP_FR_7F));

    // Reset in the middle of a frame
    base_done = done_cnt_a;
    addr_a = 13'd9;
    wait_cs_low_a(50);
    tick(1);
    n = 0;
    while (bitn_a < 8 && n < 100) begin tick(1); n++; end
    chk("bit8_reached", 32'(bitn_a), 32'd8);
    rst_a = 1'b1;
    tick(1);
    chk("abort_cs_n",   32'(cs_a),   32'd1);
    chk("abort_sclk",   32'(sclk_a), 32'd0);
    chk("abort_ldac_n", 32'(ldac_a), 32'd1);
    chk("abort_busy",   32'(busy_a), 32'd0);
    addr_a = 13'd0;
    tick(2);
    chk("abort_no_done", 32'(done_cnt_a - base_done), 32'd0);
    base_rd = rd_cnt_a;
    rst_a = 1'b0;
    wait_done_a(base_done + 1, 300);
    tick(5);
    chk("refetch_addr",  32'(rd_addr_a),           32'd0);
    chk("refetch_rd",    32'(rd_cnt_a - base_rd),  32'd1);
    chk("refetch_frame", 32'(frame_a),             32'(EXP_FR_A5));
    chk("mosi_on_fall",  32'(edge_err_a),          32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wave_dac_driver.md
Name: wave_dac_driver

Overview:
- Consumes the 13-bit wavetable address produced by the NCO stage.
- On every address change, fetches the sample from wavetable RAM.
- Serialises the sample as a 16-bit SPI frame to an external 12-bit DAC (MCP4921-style), then pulses LDAC.
- Sits directly downstream of the NCO; one instance per voice.

Parameters:
- ADDR_W, 13, wavetable RAM address width ({wave[5:0], sample[6:0]}).
- SAMPLE_W, 8, RAM sample width; must be ≤ 12.
- RAM_LAT, 1, RAM read latency in i_clock cycles (1..3).
- CLK_DIV, 2, i_clock cycles per SCLK half-period (≥ 1).
- DAC_CFG, 4'b0011, upper 4 bits of each frame: A/B=0, BUF=0, GA_n=1, SHDN_n=1.

Ports:
- i_clock, in, 1, system clock; all logic on posedge.
- i_reset, in, 1, synchronous, active-high reset.
- i_address, in, ADDR_W, wavetable address from the NCO; may change at any cycle.
- o_ram_addr, out, ADDR_W, RAM read address.
- o_ram_rd_en, out, 1, one-cycle RAM read strobe.
- i_ram_data, in, SAMPLE_W, RAM read data, valid RAM_LAT cycles after o_ram_rd_en.
- o_dac_cs_n, out, 1, DAC chip select, active low.
- o_dac_sclk, out, 1, DAC serial clock; idles low.
- o_dac_mosi, out, 1, DAC serial data, MSB first.
- o_dac_ldac_n, out, 1, DAC latch strobe, active low.
- o_sample, out, SAMPLE_W, last sample sent (after optional conversion).
- o_busy, out, 1, high in any state other than IDLE.
- o_frame_done, out, 1, one-cycle pulse when LDAC is released.

Behaviour:
- Reset values:
  - cs_n=1, sclk=0, mosi=0, ldac_n=1.
  - rd_en=0, ram_addr=0, o_sample=0, busy=0, frame_done=0.
  - Address shadow register = 0; pending flag = 1, so sample 0 is fetched after reset.
- Reset asserted mid-frame aborts immediately. Next cycle outputs are at reset values, with no partial LDAC.
- Change detect:
  - i_address is registered every cycle.
  - If i_address != shadow, the shadow is updated and pending is set.
  - Pending is cleared when the READ state samples the shadow.
  - Changes during a frame coalesce: only the newest address is fetched next (no queue).
- FSM states: IDLE, READ, WAIT, LOAD, SHIFT, LATCH.
  - IDLE: if pending -> READ.
  - READ: ram_addr <= shadow; rd_en pulses 1 cycle; clear pending -> WAIT.
  - WAIT: count RAM_LAT cycles, then capture i_ram_data -> LOAD.
  - LOAD: build frame {DAC_CFG, sample, (12-SAMPLE_W) zeros}; cs_n <= 0; mosi <= frame[15]; o_sample updated -> SHIFT.
  - SHIFT:
    - 16 bits; each bit is CLK_DIV cycles sclk low then CLK_DIV cycles sclk high.
    - mosi changes only on sclk falling edge (start of low phase).
    - After the 16th high phase: sclk <= 0, cs_n <= 1 -> LATCH.
  - LATCH: ldac_n low for CLK_DIV cycles, then high; frame_done pulses on release -> IDLE.
- Pending set in the same cycle as READ clearing it: set wins (change-detect has priority).
- Frame length: 1 (LOAD) + 32*CLK_DIV (SHIFT) + CLK_DIV (LATCH) cycles.
- Address-change to cs_n fall: 1 (detect) + 1 (IDLE) + 1 (READ) + RAM_LAT + 1 (LOAD) cycles.

Optional Feature:
- Macro: SIGNED_SAMPLE_EN.
- Defined: RAM samples are two's complement; the sample MSB is inverted before framing (offset binary), so 8'h80 -> 8'h00 and 8'h00 -> 8'h80. o_sample holds the converted value.
- Undefined: samples pass unmodified (unsigned).

Decomposition:
- Shared package synth_pkg:
  - FSM state enum.
  - DAC frame width constant (16).
  - DAC_CFG default.
  - Wavetable geometry constants: 64 waves, 128 samples per wave, ADDR_W = 13.
- One sub-module, spi_tx_shifter: 16-bit shift register plus SCLK divider, CS control and done flag.
- Top module owns change detect, RAM fetch, LDAC and the FSM.

Test Plan:
- Reset release with RAM returning 8'hA5 at address 0 (CLK_DIV=2, RAM_LAT=1) -> one frame; MOSI bits 16'h3A50; cs_n low for 64 cycles; ldac_n low for 2 cycles; frame_done pulses once.
- Static i_address after the first frame -> no further rd_en and busy stays 0 for 200 cycles.
- i_address changes 0x0005 -> 0x0006 -> 0x0007 during one SHIFT -> exactly one further frame, and it reads address 0x0007.
- i_reset asserted at bit 8 of a frame -> next cycle cs_n=1, sclk=0, ldac_n=1; no frame_done; sample 0 re-fetched after release.
- SIGNED_SAMPLE_EN defined, RAM data 8'h80 -> frame 16'h3000; data 8'h7F -> 16'h3FF0.
- RAM_LAT=3, CLK_DIV=1 -> rd_en to data capture is 3 cycles; SCLK period is 2 cycles; frame spans 32 SHIFT cycles.
